text_overlay: RTL and testbench

Renders a fixed-position line of ASCII text into the VGA pixel stream using the 8x8 font ROM (`text_gen`). The block holds a writable character buffer and steps through it in raster order: for each incoming pixel coordinate it drives `char_addr`/`row_addr` to the font ROM, takes back the returned `bitmap` row, and emits a per-pixel `pixel_on` flag two cycles later. Game logic writes score/status strings through a simple write port. The colour mux downstream consumes `pixel_on`.

---
 rtl/text_overlay_if.sv | 29 ++
 rtl/text_overlay.sv | 144 ++++++++++++++
 tb/tb_text_overlay.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_overlay_if.sv
// Pixel, buffer-write and font-ROM signals between the text overlay and its surroundings.
// master = raster/game/font side, slave = text_overlay.
interface text_overlay_if #(
    parameter int unsigned IDX_W = 4
);
    logic             de;
    logic [9:0]       hcount;
    logic [9:0]       vcount;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_char;
    logic             clear;
    logic             busy;
    logic [7:0]       char_addr;
    logic [2:0]       row_addr;
    logic [7:0]       bitmap;
    logic             pixel_valid;
    logic             pixel_on;

    modport master (
        output de, hcount, vcount, wr_en, wr_idx, wr_char, clear, bitmap,
        input  busy, char_addr, row_addr, pixel_valid, pixel_on
    );

    modport slave (
        input  de, hcount, vcount, wr_en, wr_idx, wr_char, clear, bitmap,
        output busy, char_addr, row_addr, pixel_valid, pixel_on
    );
endinterface

// File: rtl/text_overlay.sv
// Fixed-position text line overlay: writable character buffer, clear FSM and a
// two-stage render pipeline that looks glyph rows up in an external 8x8 font ROM.
module text_overlay #(
    parameter int unsigned X0         = 8,
    parameter int unsigned Y0         = 8,
    parameter int unsigned NUM_CHARS  = 16,
    parameter int unsigned SCALE_LOG2 = 0
) (
    input  logic          clk,
    input  logic          reset,
    text_overlay_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_CHARS);
    localparam int unsigned W     = (NUM_CHARS * 8) << SCALE_LOG2;
    localparam int unsigned H     = 8 << SCALE_LOG2;

    localparam logic [9:0]       X_LO     = 10'(X0);
    localparam logic [9:0]       X_HI     = 10'(X0 + W);
    localparam logic [9:0]       Y_LO     = 10'(Y0);
    localparam logic [9:0]       Y_HI     = 10'(Y0 + H);
    localparam logic [IDX_W:0]   NUM_LIM  = (IDX_W + 1)'(NUM_CHARS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);
    localparam logic [7:0]       SPACE    = 8'h20;

    if (NUM_CHARS < 2) begin : g_chk_num_chars
        $error("text_overlay: NUM_CHARS must be at least 2");
    end
    if (SCALE_LOG2 > 2) begin : g_chk_scale
        $error("text_overlay: SCALE_LOG2 must be 0..2");
    end
    if (X0 + W > 1023) begin : g_chk_width
        $error("text_overlay: text box exceeds horizontal range");
    end
    if (Y0 + H > 1023) begin : g_chk_height
        $error("text_overlay: text box exceeds vertical range");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] clr_idx;
    logic [7:0]       char_buf [NUM_CHARS];

    logic             wr_ok_c;
    logic             in_box_c;
    logic [9:0]       rx_c;
    logic [9:0]       ry_c;
    logic [IDX_W-1:0] idx_c;
    logic [2:0]       col_c;
    logic [2:0]       row_c;

    logic [2:0]       col1;
    logic             in_box1;
    logic             de1;

    assign wr_ok_c = ({1'b0, bus.wr_idx} < NUM_LIM);

    // Clear FSM and buffer writes; a clear request takes priority over a same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            clr_idx  <= '0;
            bus.busy <= 1'b0;
            for (int i = 0; i < int'(NUM_CHARS); i++) begin
                char_buf[i] <= SPACE;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clear) begin
                        state    <= ST_CLEAR;
                        clr_idx  <= '0;
                        bus.busy <= 1'b1;
                    end else if (bus.wr_en && wr_ok_c) begin
                        char_buf[bus.wr_idx] <= bus.wr_char;
                    end
                end
                ST_CLEAR: begin
                    char_buf[clr_idx] <= SPACE;
                    if (clr_idx == LAST_IDX) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0: box test and glyph coordinates from the raster position.
    always_comb begin
        in_box_c = 1'b0;
        rx_c     = '0;
        ry_c     = '0;
        idx_c    = '0;
        col_c    = '0;
        row_c    = '0;
        in_box_c = (bus.hcount >= X_LO) && (bus.hcount < X_HI) &&
                   (bus.vcount >= Y_LO) && (bus.vcount < Y_HI);
        if (in_box_c) begin
            rx_c  = bus.hcount - X_LO;
            ry_c  = bus.vcount - Y_LO;
            idx_c = IDX_W'(rx_c >> (3 + SCALE_LOG2));
            col_c = 3'(rx_c >> SCALE_LOG2);
            row_c = 3'(ry_c >> SCALE_LOG2);
        end
    end

    // Stage 1: font ROM address plus the per-pixel context that travels with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.char_addr <= SPACE;
            bus.row_addr  <= '0;
            col1          <= '0;
            in_box1       <= 1'b0;
            de1           <= 1'b0;
        end else begin
            bus.char_addr <= in_box_c ? char_buf[idx_c] : SPACE;
            bus.row_addr  <= in_box_c ? row_c : 3'd0;
            col1          <= col_c;
            in_box1       <= in_box_c;
            de1           <= bus.de;
        end
    end

    // Stage 2: pick the glyph bit; bitmap bit 7 is the leftmost pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pixel_on    <= 1'b0;
            bus.pixel_valid <= 1'b0;
        end else begin
            bus.pixel_on    <= de1 & in_box1 & bus.bitmap[3'd7 - col1];
            bus.pixel_valid <= de1;
        end
    end
endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: a default instance and a 2x scaled, 12-character
// instance, each fed by a small behavioural font ROM.
module tb_text_overlay;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    text_overlay_if #(.IDX_W(4)) bus0 ();
    text_overlay_if #(.IDX_W(4)) bus1 ();

    text_overlay u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    text_overlay #(.NUM_CHARS(12), .SCALE_LOG2(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] font(input logic [7:0] c, input logic [2:0] r);
        logic [63:0] g;
        case (c)
            8'h53:   g = 64'h7CC6C07C06C67C00;
            8'h30:   g = 64'h7CC6CED6E6C67C00;
            8'h31:   g = 64'h307030303030FC00;
            8'h41:   g = 64'h386CC6FEC6C6C600;
            default: g = 64'h0;
        endcase
        return g[63 - 8*int'(r) -: 8];
    endfunction

    always_comb bus0.bitmap = font(bus0.char_addr, bus0.row_addr);
    always_comb bus1.bitmap = font(bus1.char_addr, bus1.row_addr);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus0.de = 0; bus0.hcount = '0; bus0.vcount = '0;
        bus0.wr_en = 0; bus0.wr_idx = '0; bus0.wr_char = '0; bus0.clear = 0;
        bus1.de = 0; bus1.hcount = '0; bus1.vcount = '0;
        bus1.wr_en = 0; bus1.wr_idx = '0; bus1.wr_char = '0; bus1.clear = 0;
    endtask

    task automatic write0(input logic [3:0] idx, input logic [7:0] ch);
        bus0.wr_en = 1; bus0.wr_idx = idx; bus0.wr_char = ch;
        tick;
        bus0.wr_en = 0;
    endtask

    task automatic write1(input logic [3:0] idx, input logic [7:0] ch);
        bus1.wr_en = 1; bus1.wr_idx = idx; bus1.wr_char = ch;
        tick;
        bus1.wr_en = 0;
    endtask

    task automatic test_reset;
        logic dprev;
        logic d;
        reset = 1;
        idle_inputs();
        tick; tick;
        vectors += 6;
        if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        if (bus0.char_addr !== 8'h20) begin miscompares++; $display("FAIL reset_char_addr: got %h expected 20", bus0.char_addr); end
        if (bus0.row_addr !== 3'd0) begin miscompares++; $display("FAIL reset_row_addr: got %0d expected 0", bus0.row_addr); end
        if (bus0.pixel_on !== 1'b0) begin miscompares++; $display("FAIL reset_pixel_on: got %b expected 0", bus0.pixel_on); end
        if (bus0.pixel_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pixel_valid: got %b expected 0", bus0.pixel_valid); end
        if (bus1.char_addr !== 8'h20) begin miscompares++; $display("FAIL reset_char_addr1: got %h expected 20", bus1.char_addr); end
        #2 reset = 0;
        tick;
        dprev = 0;
        for (int k = 0; k <= 1024; k++) begin
            d = (k % 5) != 0;
            if (k < 1024) begin
                bus0.de = d; bus0.hcount = 10'(8 + k % 128); bus0.vcount = 10'(8 + k / 128);
            end else begin
                bus0.de = 0;
            end
            tick;
            if (k < 1024) begin
                vectors++;
                if (bus0.char_addr !== 8'h20) begin miscompares++; $display("FAIL sweep_char_addr k=%0d: got %h expected 20", k, bus0.char_addr); end
            end
            if (k >= 1) begin
                vectors += 2;
                if (bus0.pixel_on !== 1'b0) begin miscompares++; $display("FAIL sweep_pixel_on k=%0d: got %b expected 0", k - 1, bus0.pixel_on); end
                if (bus0.pixel_valid !== dprev) begin miscompares++; $display("FAIL sweep_pixel_valid k=%0d: got %b expected %b", k - 1, bus0.pixel_valid, dprev); end
            end
            dprev = d;
        end
        idle_inputs();
    endtask

    task automatic test_glyph;
        logic [7:0] exp_row;
        exp_row = 8'b0111_1100;
        write0(4'd0, 8'h53);
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                bus0.de = 1; bus0.hcount = 10'(8 + k); bus0.vcount = 10'd8;
            end else begin
                bus0.de = 0;
            end
            tick;
            if (k < 8) begin
                vectors += 2;
                if (bus0.char_addr !== 8'h53) begin miscompares++; $display("FAIL glyph_char_addr k=%0d: got %h expected 53", k, bus0.char_addr); end
                if (bus0.row_addr !== 3'd0) begin miscompares++; $display("FAIL glyph_row_addr k=%0d: got %0d expected 0", k, bus0.row_addr); end
            end
            if (k >= 1) begin
                vectors++;
                if (bus0.pixel_on !== exp_row[8 - k]) begin miscompares++; $display("FAIL glyph_pixel_on col=%0d: got %b expected %b", k - 1, bus0.pixel_on, exp_row[8 - k]); end
            end
        end
        // Lookup in the same cycle as a write sees the old character.
        bus0.de = 1; bus0.hcount = 10'd8; bus0.vcount = 10'd8;
        bus0.wr_en = 1; bus0.wr_idx = 4'd0; bus0.wr_char = 8'h41;
        tick;
        bus0.wr_en = 0;
        vectors++;
        if (bus0.char_addr !== 8'h53) begin miscompares++; $display("FAIL write_old_value: got %h expected 53", bus0.char_addr); end
        tick;
        vectors++;
        if (bus0.char_addr !== 8'h41) begin miscompares++; $display("FAIL write_new_value: got %h expected 41", bus0.char_addr); end
        idle_inputs();
    endtask

    task automatic test_edges;
        int   hs [8];
        int   vs [8];
        logic ds [8];
        logic es [8];
        hs = '{7, 136, 20, 20, 10, 10, 9, 8};
        vs = '{12, 12, 7, 16, 12, 12, 9, 12};
        ds = '{1, 1, 1, 1, 1, 0, 1, 1};
        es = '{0, 0, 0, 0, 1, 0, 1, 1};
        for (int i = 0; i < 16; i++) write0(4'(i), 8'h30);
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                bus0.de = ds[k]; bus0.hcount = 10'(hs[k]); bus0.vcount = 10'(vs[k]);
            end else begin
                bus0.de = 0;
            end
            tick;
            if (k >= 1) begin
                vectors += 2;
                if (bus0.pixel_on !== es[k - 1]) begin miscompares++; $display("FAIL edge_pixel_on h=%0d v=%0d: got %b expected %b", hs[k - 1], vs[k - 1], bus0.pixel_on, es[k - 1]); end
                if (bus0.pixel_valid !== ds[k - 1]) begin miscompares++; $display("FAIL edge_pixel_valid h=%0d v=%0d: got %b expected %b", hs[k - 1], vs[k - 1], bus0.pixel_valid, ds[k - 1]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear;
        int n;
        for (int i = 0; i < 16; i++) write0(4'(i), 8'(8'h41 + i));
        bus0.clear = 1; bus0.wr_en = 1; bus0.wr_idx = 4'd3; bus0.wr_char = 8'h41;
        tick;
        vectors++;
        if (bus0.busy !== 1'b1) begin miscompares++; $display("FAIL clear_busy_rise: got %b expected 1", bus0.busy); end
        n = 1;
        for (int c = 0; c < 40 && bus0.busy; c++) begin
            tick;
            if (c == 8) begin bus0.wr_en = 0; bus0.clear = 0; end
            if (bus0.busy) n++;
        end
        bus0.wr_en = 0; bus0.clear = 0;
        vectors += 2;
        if (n !== 16) begin miscompares++; $display("FAIL clear_busy_cycles: got %0d expected 16", n); end
        if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL clear_busy_fall: got %b expected 0", bus0.busy); end
        tick;
        for (int i = 0; i < 16; i++) begin
            bus0.de = 1; bus0.hcount = 10'(8 + 8 * i); bus0.vcount = 10'd8;
            tick;
            vectors++;
            if (bus0.char_addr !== 8'h20) begin miscompares++; $display("FAIL clear_slot%0d: got %h expected 20", i, bus0.char_addr); end
        end
        idle_inputs();
        // Out-of-range writes on the 12-slot instance land nowhere.
        write1(4'd12, 8'h41);
        write1(4'd15, 8'h41);
        for (int i = 0; i < 12; i++) begin
            bus1.de = 1; bus1.hcount = 10'(8 + 16 * i); bus1.vcount = 10'd8;
            tick;
            vectors++;
            if (bus1.char_addr !== 8'h20) begin miscompares++; $display("FAIL oor_write_slot%0d: got %h expected 20", i, bus1.char_addr); end
        end
        idle_inputs();
    endtask

    task automatic test_scale;
        int   hs [33];
        int   vs [33];
        logic es [33];
        logic [2:0] rs [33];
        logic [7:0] g0;
        g0 = 8'b0011_0000;
        for (int i = 0; i < 32; i++) begin
            hs[i] = 24 + (i % 16);
            vs[i] = 8 + i / 16;
            rs[i] = 3'd0;
            es[i] = g0[7 - (((hs[i] - 8) >> 1) & 7)];
        end
        hs[32] = 26; vs[32] = 10; rs[32] = 3'd1; es[32] = 1'b1;
        write1(4'd1, 8'h31);
        for (int k = 0; k <= 33; k++) begin
            if (k < 33) begin
                bus1.de = 1; bus1.hcount = 10'(hs[k]); bus1.vcount = 10'(vs[k]);
            end else begin
                bus1.de = 0;
            end
            tick;
            if (k < 33) begin
                vectors += 2;
                if (bus1.char_addr !== 8'h31) begin miscompares++; $display("FAIL scale_char_addr h=%0d: got %h expected 31", hs[k], bus1.char_addr); end
                if (bus1.row_addr !== rs[k]) begin miscompares++; $display("FAIL scale_row_addr h=%0d v=%0d: got %0d expected %0d", hs[k], vs[k], bus1.row_addr, rs[k]); end
            end
            if (k >= 1) begin
                vectors++;
                if (bus1.pixel_on !== es[k - 1]) begin miscompares++; $display("FAIL scale_pixel_on h=%0d v=%0d: got %b expected %b", hs[k - 1], vs[k - 1], bus1.pixel_on, es[k - 1]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear;
        int n;
        write0(4'd5, 8'h41);
        bus0.clear = 1;
        tick;
        bus0.clear = 0;
        repeat (5) tick;
        vectors++;
        if (bus0.busy !== 1'b1) begin miscompares++; $display("FAIL midclear_busy: got %b expected 1", bus0.busy); end
        #2 reset = 1;
        #1;
        vectors++;
        if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL async_reset_busy: got %b expected 0", bus0.busy); end
        tick;
        #2 reset = 0;
        tick;
        vectors++;
        if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy: got %b expected 0", bus0.busy); end
        for (int i = 0; i < 16; i++) begin
            bus0.de = 1; bus0.hcount = 10'(8 + 8 * i); bus0.vcount = 10'd8;
            tick;
            vectors++;
            if (bus0.char_addr !== 8'h20) begin miscompares++; $display("FAIL post_reset_slot%0d: got %h expected 20", i, bus0.char_addr); end
        end
        idle_inputs();
        bus0.clear = 1;
        tick;
        bus0.clear = 0;
        n = bus0.busy ? 1 : 0;
        for (int c = 0; c < 40 && bus0.busy; c++) begin
            tick;
            if (bus0.busy) n++;
        end
        vectors++;
        if (n !== 16) begin miscompares++; $display("FAIL reclear_busy_cycles: got %0d expected 16", n); end
        idle_inputs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_glyph();
        test_edges();
        test_clear();
        test_scale();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
